// File: rtl/chi_pkg.sv
// chi_pkg: shared definitions for the chi scheduler.
//   - default widths for chi values and transfer counters
//   - FSM state encoding
//   - SEL source-index constants and a mod-3 increment helper
package chi_pkg;

  localparam int PARAMETERBITS_DEF = 14;
  localparam int CNTBITS_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] SEL_CHI1 = 2'd0;
  localparam logic [1:0] SEL_CHI2 = 2'd1;
  localparam logic [1:0] SEL_CHI3 = 2'd2;

  // Next source index, wrapping CHI3 back to CHI1.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == SEL_CHI3) ? SEL_CHI1 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//   REQ   [2:0] request vector (bit0 = CHI1 .. bit2 = CHI3)
//   LAST  [1:0] index of the previous winner; search starts at LAST+1 mod 3
//   VALID       at least one request present
//   WIN   [1:0] winning index (SEL_CHI1 when VALID is low)
module rr_pick3
  import chi_pkg::*;
(
  input  logic [2:0] REQ,
  input  logic [1:0] LAST,
  output logic       VALID,
  output logic [1:0] WIN
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    cand0 = next_idx(LAST);
    cand1 = next_idx(cand0);
    cand2 = next_idx(cand1);
    VALID = |REQ;
    WIN   = SEL_CHI1;
    if (REQ[cand0])      WIN = cand0;
    else if (REQ[cand1]) WIN = cand1;
    else if (REQ[cand2]) WIN = cand2;
  end

endmodule

// File: rtl/chi_sched.sv
// chi_sched: arbitrates three chi fitters onto one output, compares the
// selected chi against a cut and counts passing/failing transfers.
//   CLOCK, RESETN        clock, synchronous active-low reset
//   REQ[2:0]             per-fitter request
//   CHI1/CHI2/CHI3       chi values, stable while the matching REQ is high
//   CHI_CUT              acceptance threshold, sampled at the LOAD edge
//   OUT_READY            downstream accepts CHI (transfer when in HOLD)
//   CLEAR                zero both counters
//   GNT[2:0]             one-cycle one-hot grant pulse
//   SEL[1:0]             current source index
//   CHI, CHI_PASS        registered chi and its pass flag
//   CHI_VALID            CHI/CHI_PASS valid (HOLD)
//   NPASS, NFAIL         saturating transfer counters
//
// state | meaning
// IDLE  | waiting for a request; winner chosen on the exit edge
// LOAD  | grant pulse; chi and pass flag captured on the exit edge
// HOLD  | CHI_VALID high until OUT_READY completes the transfer
module chi_sched
  import chi_pkg::*;
#(
  parameter int PARAMETERBITS = PARAMETERBITS_DEF,
  parameter int CNTBITS       = CNTBITS_DEF
) (
  input  logic                     CLOCK,
  input  logic                     RESETN,
  input  logic [2:0]               REQ,
  input  logic [PARAMETERBITS-1:0] CHI1,
  input  logic [PARAMETERBITS-1:0] CHI2,
  input  logic [PARAMETERBITS-1:0] CHI3,
  input  logic [PARAMETERBITS-1:0] CHI_CUT,
  input  logic                     OUT_READY,
  input  logic                     CLEAR,
  output logic [2:0]               GNT,
  output logic [1:0]               SEL,
  output logic [PARAMETERBITS-1:0] CHI,
  output logic                     CHI_VALID,
  output logic                     CHI_PASS,
  output logic [CNTBITS-1:0]       NPASS,
  output logic [CNTBITS-1:0]       NFAIL
);

  state_t                   state_q, state_d;
  logic [1:0]               sel_q, sel_d;
  logic [1:0]               last_q, last_d;
  logic [PARAMETERBITS-1:0] chi_q, chi_d;
  logic                     pass_q, pass_d;
  logic [CNTBITS-1:0]       npass_q, npass_d;
  logic [CNTBITS-1:0]       nfail_q, nfail_d;

  logic                     pick_valid;
  logic [1:0]               pick_win;
  logic [PARAMETERBITS-1:0] chi_mux;
  logic                     xfer;

  rr_pick3 u_pick (
    .REQ   (REQ),
    .LAST  (last_q),
    .VALID (pick_valid),
    .WIN   (pick_win)
  );

  always_comb begin
    case (sel_q)
      SEL_CHI2: chi_mux = CHI2;
      SEL_CHI3: chi_mux = CHI3;
      default:  chi_mux = CHI1;
    endcase
  end

  assign xfer = (state_q == ST_HOLD) && OUT_READY;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    chi_d   = chi_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_win;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        chi_d   = chi_mux;
        pass_d  = (chi_mux <= CHI_CUT);
        last_d  = sel_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CLEAR has priority over a transfer landing on the same edge.
  always_comb begin
    npass_d = npass_q;
    nfail_d = nfail_q;
    if (CLEAR) begin
      npass_d = '0;
      nfail_d = '0;
    end else if (xfer) begin
      if (pass_q) begin
        if (npass_q != '1) npass_d = npass_q + CNTBITS'(1);
      end else begin
        if (nfail_q != '1) nfail_d = nfail_q + CNTBITS'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_CHI1;
      last_q  <= SEL_CHI3;  // CHI1 gets first priority after reset
      chi_q   <= '0;
      pass_q  <= 1'b0;
      npass_q <= '0;
      nfail_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      chi_q   <= chi_d;
      pass_q  <= pass_d;
      npass_q <= npass_d;
      nfail_q <= nfail_d;
    end
  end

  assign GNT       = (state_q == ST_LOAD) ? (3'b001 << sel_q) : 3'b000;
  assign SEL       = sel_q;
  assign CHI       = chi_q;
  assign CHI_VALID = (state_q == ST_HOLD);
  assign CHI_PASS  = pass_q;
  assign NPASS     = npass_q;
  assign NFAIL     = nfail_q;

endmodule

// File: tb/tb_chi_sched.sv
// tb_chi_sched: randomized scoreboard bench for chi_sched.
// Stimulus pushes expected grants and transfers into queues; a negedge
// monitor pops and compares them, and tracks the expected counters.
module tb_chi_sched;

  localparam int PB = 14;
  localparam int CB = 4;

  logic          CLOCK = 1'b0;
  logic          RESETN = 1'b0;
  logic [2:0]    REQ = 3'b000;
  logic [PB-1:0] CHI1 = '0, CHI2 = '0, CHI3 = '0, CHI_CUT = '0;
  logic          OUT_READY = 1'b0;
  logic          CLEAR = 1'b0;
  logic [2:0]    GNT;
  logic [1:0]    SEL;
  logic [PB-1:0] CHI;
  logic          CHI_VALID, CHI_PASS;
  logic [CB-1:0] NPASS, NFAIL;

  chi_sched #(.PARAMETERBITS(PB), .CNTBITS(CB)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .REQ(REQ),
    .CHI1(CHI1), .CHI2(CHI2), .CHI3(CHI3), .CHI_CUT(CHI_CUT),
    .OUT_READY(OUT_READY), .CLEAR(CLEAR),
    .GNT(GNT), .SEL(SEL), .CHI(CHI), .CHI_VALID(CHI_VALID),
    .CHI_PASS(CHI_PASS), .NPASS(NPASS), .NFAIL(NFAIL)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct { logic [2:0] gnt; int cyc; } gexp_t;
  typedef struct { logic [PB-1:0] chi; logic pass; logic [1:0] sel; int vcyc; } xexp_t;

  gexp_t gq[$];
  xexp_t xq[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  int model_last = 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference arbitration: first requester found scanning upward from last+1.
  function automatic int pick(input logic [2:0] r, input int last);
    for (int i = 1; i <= 3; i++)
      if (r[(last + i) % 3]) return (last + i) % 3;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  bit            seen = 1'b0;
  bit            rst_pending = 1'b0;
  bit            cnt_armed = 1'b0;
  int            exp_np = 0, exp_nf = 0;
  localparam int SAT = (1 << CB) - 1;

  always @(negedge CLOCK) begin
    bit xf;
    bit xp;
    xf = 1'b0;
    xp = 1'b0;
    if (mon_en) begin
      if (cnt_armed) begin
        chk("npass", 32'(NPASS), 32'(exp_np));
        chk("nfail", 32'(NFAIL), 32'(exp_nf));
      end
      if (rst_pending) begin
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_sel", 32'(SEL), 0);
        chk("rst_chi", 32'(CHI), 0);
        chk("rst_valid", 32'(CHI_VALID), 0);
        chk("rst_pass", 32'(CHI_PASS), 0);
        rst_pending = 1'b0;
      end
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        chk("gnt", 32'(GNT), 32'(gq[0].gnt));
        void'(gq.pop_front());
      end else if (GNT !== 3'b000) begin
        chk("gnt_spurious", 32'(GNT), 0);
      end
      if (xq.size() > 0) begin
        if (!seen && cyc == xq[0].vcyc) begin
          chk("valid_latency", 32'(CHI_VALID), 1);
          seen = 1'b1;
        end else if (!seen && CHI_VALID !== 1'b0) begin
          chk("valid_early", 32'(CHI_VALID), 0);
        end
        if (seen) begin
          chk("valid_hold", 32'(CHI_VALID), 1);
          chk("chi", 32'(CHI), 32'(xq[0].chi));
          chk("chi_pass", 32'(CHI_PASS), 32'(xq[0].pass));
          chk("sel", 32'(SEL), 32'(xq[0].sel));
          if (OUT_READY && RESETN) begin
            xf = 1'b1;
            xp = xq[0].pass;
            void'(xq.pop_front());
            seen = 1'b0;
          end
        end
      end else if (CHI_VALID !== 1'b0) begin
        chk("valid_spurious", 32'(CHI_VALID), 0);
      end
      if (!RESETN || CLEAR) begin
        exp_np = 0;
        exp_nf = 0;
      end else if (xf) begin
        if (xp) exp_np = (exp_np == SAT) ? SAT : exp_np + 1;
        else    exp_nf = (exp_nf == SAT) ? SAT : exp_nf + 1;
      end
      if (!RESETN) begin
        gq.delete();
        xq.delete();
        seen = 1'b0;
        rst_pending = 1'b1;
        cnt_armed = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge with the DUT idle for the coming cycle.
  task automatic run_txn(input logic [2:0] req, input bit keep, input int h,
                         input logic [PB-1:0] c1, input logic [PB-1:0] c2,
                         input logic [PB-1:0] c3, input logic [PB-1:0] cut,
                         input logic [PB-1:0] cut2, input bit clr, input bit abort);
    int w;
    logic [PB-1:0] cw;
    w  = pick(req, model_last);
    cw = (w == 0) ? c1 : (w == 1) ? c2 : c3;
    model_last = w;
    gq.push_back('{gnt: 3'(1 << w), cyc: cyc + 1});
    xq.push_back('{chi: cw, pass: (cw <= cut), sel: 2'(w), vcyc: cyc + 2});
    REQ = req; CHI1 = c1; CHI2 = c2; CHI3 = c3; CHI_CUT = cut;
    OUT_READY = 1'b0; CLEAR = 1'b0;
    @(posedge CLOCK) #1;  // LOAD
    REQ = keep ? req : 3'($urandom);
    OUT_READY = 1'($urandom);
    @(posedge CLOCK) #1;  // first HOLD cycle
    CHI1 = PB'($urandom); CHI2 = PB'($urandom); CHI3 = PB'($urandom);
    CHI_CUT = cut2;
    OUT_READY = 1'b0;
    REQ = keep ? req : 3'($urandom);
    repeat (h) begin
      @(posedge CLOCK) #1;
      REQ = keep ? req : 3'($urandom);
    end
    if (abort) begin
      RESETN = 1'b0; OUT_READY = 1'b1; CLEAR = 1'b1; REQ = 3'b000;
      @(posedge CLOCK) #1;
      RESETN = 1'b1; OUT_READY = 1'b0; CLEAR = 1'b0;
      model_last = 2;
    end else begin
      OUT_READY = 1'b1; CLEAR = clr;
      REQ = keep ? req : 3'b000;
      @(posedge CLOCK) #1;
      OUT_READY = 1'b0; CLEAR = 1'b0; REQ = 3'b000;
    end
  endtask

  task automatic do_reset();
    RESETN = 1'b0; REQ = 3'b000; OUT_READY = 1'b0; CLEAR = 1'b0;
    repeat (2) @(posedge CLOCK) #1;
    RESETN = 1'b1;
    model_last = 2;
  endtask

  initial begin
    @(posedge CLOCK) #1;
    mon_en = 1'b1;
    @(posedge CLOCK) #1;
    RESETN = 1'b1;

    // single CHI2 request, passing
    run_txn(3'b010, 1'b0, 0, 14'd7, 14'd100, 14'd9, 14'd200, 14'd200, 1'b0, 1'b0);
    repeat (4) @(posedge CLOCK) #1;  // idle, no grants expected

    // all requests held, back-to-back transfers
    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(3'b111, 1'b1, 0, PB'($urandom), PB'($urandom), PB'($urandom),
              PB'($urandom), PB'($urandom), 1'b0, 1'b0);

    // CHI3 fails, long hold, cut raised mid-hold
    run_txn(3'b100, 1'b0, 5, 14'd1, 14'd2, 14'd300, 14'd299, 14'd400, 1'b0, 1'b0);

    // counter saturation then clear on a transfer edge
    do_reset();
    for (int i = 0; i < 17; i++)
      run_txn(3'($urandom_range(1, 7)), 1'b0, $urandom_range(0, 1),
              PB'($urandom), PB'($urandom), PB'($urandom),
              14'h3fff, PB'($urandom), 1'b0, 1'b0);
    run_txn(3'b001, 1'b0, 0, 14'd5, 14'd5, 14'd5, 14'd10, 14'd10, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++)
      run_txn(3'($urandom_range(1, 7)), 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), PB'($urandom), PB'($urandom), PB'($urandom),
              PB'($urandom), PB'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);

    // reset during HOLD, then CHI1 must win first
    run_txn(3'b010, 1'b0, 2, 14'd50, 14'd60, 14'd70, 14'd100, 14'd100, 1'b0, 1'b1);
    run_txn(3'b111, 1'b0, 0, 14'd11, 14'd22, 14'd33, 14'd20, 14'd20, 1'b0, 1'b0);

    repeat (3) @(posedge CLOCK) #1;
    chk("gq_empty", 32'(gq.size()), 0);
    chk("xq_empty", 32'(xq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chi_sched.md
CHI_SCHED -- requirements
Module: chi_sched

Interface
REQ-001 SHALL have parameter PARAMETERBITS, default 14, the chi value width.
REQ-002 SHALL have parameter CNTBITS, default 16, the pass/fail counter width.
REQ-003 SHALL have port CLOCK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port REQ, input, 3 bits: per-fitter request; bit0 = CHI1, bit1 = CHI2, bit2 = CHI3.
REQ-006 SHALL have ports CHI1, CHI2 and CHI3, input, PARAMETERBITS each: chi values; each is held stable by its requester while its REQ is high.
REQ-007 SHALL have port CHI_CUT, input, PARAMETERBITS: chi acceptance threshold.
REQ-008 SHALL have port OUT_READY, input, 1 bit: downstream accepts CHI.
REQ-009 SHALL have port CLEAR, input, 1 bit: synchronous clear of both counters.
REQ-010 SHALL have port GNT, output, 3 bits: one-hot, one-cycle grant pulse to the winner.
REQ-011 SHALL have port SEL, output, 2 bits: current source index (00 = CHI1, 01 = CHI2, 10 = CHI3); 11 is never driven.
REQ-012 SHALL have port CHI, output, PARAMETERBITS: the registered selected chi value.
REQ-013 SHALL have port CHI_VALID, output, 1 bit: CHI and CHI_PASS are valid.
REQ-014 SHALL have port CHI_PASS, output, 1 bit: high when CHI <= CHI_CUT, unsigned.
REQ-015 SHALL have ports NPASS and NFAIL, output, CNTBITS each: the transfer counters.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD and HOLD; all outputs SHALL be registered or decoded from the state.
REQ-017 In IDLE with REQ != 0, the block SHALL pick a winner w by round-robin starting at LAST+1 mod 3, set SEL = w, and go to LOAD. With REQ == 0 it SHALL stay in IDLE.
REQ-018 In LOAD (exactly one cycle):
- GNT[w] = 1 and all other GNT bits 0.
- At the closing edge: CHI <= CHI(w+1), CHI_PASS <= (CHI(w+1) <= CHI_CUT), LAST <= w, state <= HOLD.
REQ-019 In HOLD, CHI_VALID SHALL be 1 and CHI, CHI_PASS and SEL SHALL stay constant. On the edge where OUT_READY = 1 (transfer), the FSM SHALL go to IDLE.
REQ-020 Latency: REQ sampled at edge t -> GNT high in cycle t+1 -> CHI_VALID high from cycle t+2. Minimum spacing between transfers SHALL be 3 cycles.
REQ-021 A requester SHALL drop REQ after seeing GNT. A REQ still high in the following IDLE SHALL be treated as a new request and arbitrated by round-robin.
REQ-022 REQ changes during LOAD or HOLD SHALL be ignored. The winner SHALL NOT change after IDLE.
REQ-023 On transfer, NPASS SHALL increment if CHI_PASS = 1, otherwise NFAIL SHALL increment. Both counters SHALL saturate at all-ones.
REQ-024 CLEAR = 1 SHALL zero both counters. CLEAR SHALL win over a simultaneous increment.
REQ-025 CHI_CUT SHALL be sampled only at the LOAD edge. A later CHI_CUT change SHALL NOT alter CHI_PASS.
REQ-026 All three REQ bits high continuously SHALL produce grant order 0,1,2,0,... and no starvation.

Reset
REQ-027 With RESETN = 0 at an edge, the block SHALL enter IDLE and set: GNT = 000, SEL = 00, CHI = 0, CHI_VALID = 0, CHI_PASS = 0, NPASS = 0, NFAIL = 0, LAST = 2, so that CHI1 has first priority.
REQ-028 Reset during LOAD or HOLD SHALL abandon the transaction with no counter increment. It SHALL override CLEAR and OUT_READY.

Structure
REQ-029 Shared package chi_pkg SHALL hold:
- the FSM state encoding;
- the SEL constants SEL_CHI1, SEL_CHI2 and SEL_CHI3;
- the default PARAMETERBITS and CNTBITS.
REQ-030 The combinational round-robin picker SHALL be the sub-module rr_pick3 (inputs REQ and LAST; outputs VALID and WIN[1:0]). Everything else SHALL be in chi_sched.

Verification
REQ-031 Reset, then REQ = 010 with CHI2 = 100 and CHI_CUT = 200:
- GNT = 010 in cycle 1;
- CHI_VALID from cycle 2 with CHI = 100 and CHI_PASS = 1;
- OUT_READY = 1 -> NPASS = 1.
REQ-032 REQ = 111 held, OUT_READY = 1: GNT sequence is 001, 010, 100, 001, with transfers every 3 cycles.
REQ-033 CHI3 = 300, CHI_CUT = 299, OUT_READY = 0 for 5 cycles:
- CHI_VALID held and CHI constant;
- CHI_CUT changed to 400 mid-HOLD -> CHI_PASS stays 0;
- release OUT_READY -> NFAIL = 1.
REQ-034 With CNTBITS = 4, 17 passing transfers -> NPASS = 15. CLEAR asserted on a transfer edge -> NPASS = 0.
REQ-035 RESETN = 0 during HOLD -> next cycle CHI_VALID = 0 and counters = 0; a subsequent REQ = 111 is granted 001 first.
